// File: rtl/fft_pkg.sv
// Shared definitions for the 64-point FFT core: sizes, command encodings and
// the butterfly scheduler state encoding.
package fft_pkg;

    localparam int unsigned LOG2N   = 6;
    localparam int unsigned N       = 1 << LOG2N;
    localparam int unsigned STAGE_W = 3;

    // Command decoder encodings
    localparam logic [2:0] CMD_IDLE        = 3'b000;
    localparam logic [2:0] CMD_DATA_INPUT  = 3'b001;
    localparam logic [2:0] CMD_FFT_EXEC    = 3'b010;
    localparam logic [2:0] CMD_DATA_OUTPUT = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/fft_bf_addr.sv
// Radix-2 DIT butterfly address generator (purely combinational).
// Maps (stage s, butterfly k) to operand addresses a, b = a + 2^s and the
// twiddle index k_tw = (k mod 2^s) << (LOG2N-1-s).
// Ports:
//   stage  in  STAGE_W  stage number 0..LOG2N-1
//   k      in  LOG2N-1  butterfly index within the stage
//   a, b   out LOG2N    operand addresses
//   tw_idx out LOG2N-1  twiddle index
module fft_bf_addr #(
    parameter int unsigned LOG2N = fft_pkg::LOG2N
) (
    input  logic [fft_pkg::STAGE_W-1:0] stage,
    input  logic [LOG2N-2:0]            k,
    output logic [LOG2N-1:0]            a,
    output logic [LOG2N-1:0]            b,
    output logic [LOG2N-2:0]            tw_idx
);
    import fft_pkg::*;

    localparam int unsigned SH_W = 4;

    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] mask;
    logic [LOG2N-1:0] kx;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;
    logic [SH_W-1:0]  sh_grp;
    logic [SH_W-1:0]  sh_tw;

    // pos selects the butterfly within its group, grp the group; groups are
    // 2*half apart in memory.
    always_comb begin
        kx     = LOG2N'(k);
        half   = LOG2N'(1) << stage;
        mask   = half - LOG2N'(1);
        pos    = kx & mask;
        grp    = kx >> stage;
        sh_grp = SH_W'(stage) + SH_W'(1);
        sh_tw  = SH_W'(LOG2N - 1) - SH_W'(stage);
        a      = (grp << sh_grp) | pos;
        b      = a + half;
        tw_idx = (LOG2N-1)'(pos << sh_tw);
    end

endmodule

// File: rtl/fft_sched.sv
// In-place radix-2 DIT butterfly scheduler. On start it walks all LOG2N
// stages issuing one butterfly read per cycle, inserts BF_LAT drain cycles
// between stages so reads never overtake pending write-backs, and delays the
// read addresses by BF_LAT cycles to form the write-back strobe/addresses.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start                   begin a run (sampled in IDLE only)
//   abort                   cancel a run, flush pipeline
//   busy                    high from first read through last write
//   done                    one-cycle pulse after the final write
//   stage                   stage currently being read
//   rd_en, rd_addr_a/b      RAM read strobe and operand addresses
//   tw_idx                  twiddle index k (W = exp(-j2*pi*k/N))
//   wr_en, wr_addr_a/b      RAM write strobe and write-back addresses
module fft_sched #(
    parameter int unsigned LOG2N  = fft_pkg::LOG2N,
    parameter int unsigned BF_LAT = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic [fft_pkg::STAGE_W-1:0] stage,
    output logic                        rd_en,
    output logic [LOG2N-1:0]            rd_addr_a,
    output logic [LOG2N-1:0]            rd_addr_b,
    output logic [LOG2N-2:0]            tw_idx,
    output logic                        wr_en,
    output logic [LOG2N-1:0]            wr_addr_a,
    output logic [LOG2N-1:0]            wr_addr_b
);
    import fft_pkg::*;

    localparam int unsigned K_W   = LOG2N - 1;
    localparam int unsigned DRN_W = 3;

    localparam logic [K_W-1:0]     K_LAST     = K_W'((1 << K_W) - 1);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG2N - 1);
    localparam logic [DRN_W-1:0]   DRN_LAST   = DRN_W'(BF_LAT - 1);

    sched_state_e       state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [STAGE_W-1:0] stage_d;
    logic [DRN_W-1:0]   drain_q, drain_d;
    logic               rd_en_d;
    logic               busy_d;
    logic               done_d;
    logic [LOG2N-1:0]   rd_addr_a_d;
    logic [LOG2N-1:0]   rd_addr_b_d;
    logic [LOG2N-2:0]   tw_idx_d;

    logic [LOG2N-1:0]   bf_a;
    logic [LOG2N-1:0]   bf_b;
    logic [LOG2N-2:0]   bf_tw;

    // Write-back delay line carrying {rd_en, a, b}
    logic               sr_en [BF_LAT];
    logic [LOG2N-1:0]   sr_a  [BF_LAT];
    logic [LOG2N-1:0]   sr_b  [BF_LAT];

    fft_bf_addr #(
        .LOG2N (LOG2N)
    ) u_bf_addr (
        .stage  (stage),
        .k      (k_q),
        .a      (bf_a),
        .b      (bf_b),
        .tw_idx (bf_tw)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        stage_d     = stage;
        drain_d     = drain_q;
        rd_en_d     = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        rd_addr_a_d = rd_addr_a;
        rd_addr_b_d = rd_addr_b;
        tw_idx_d    = tw_idx;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    k_d     = '0;
                    stage_d = '0;
                end
            end
            S_RUN: begin
                rd_en_d     = 1'b1;
                busy_d      = 1'b1;
                rd_addr_a_d = bf_a;
                rd_addr_b_d = bf_b;
                tw_idx_d    = bf_tw;
                k_d         = k_q + K_W'(1);
                if (k_q == K_LAST) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                busy_d  = 1'b1;
                drain_d = drain_q + DRN_W'(1);
                if (drain_q == DRN_LAST) begin
                    if (stage == STAGE_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        stage_d = stage + STAGE_W'(1);
                        k_d     = '0;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over every transition, including start
        if (abort) begin
            state_d = S_IDLE;
            k_d     = '0;
            stage_d = '0;
            drain_d = '0;
            rd_en_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    // State, counters and registered read-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            stage     <= '0;
            drain_q   <= '0;
            rd_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_idx    <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            stage     <= stage_d;
            drain_q   <= drain_d;
            rd_en     <= rd_en_d;
            busy      <= busy_d;
            done      <= done_d;
            rd_addr_a <= rd_addr_a_d;
            rd_addr_b <= rd_addr_b_d;
            tw_idx    <= tw_idx_d;
        end
    end

    // Write-back delay line: fed from the registered read outputs so that the
    // tail lags the read by exactly BF_LAT cycles; abort flushes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BF_LAT; i++) begin
                sr_en[i] <= 1'b0;
                sr_a[i]  <= '0;
                sr_b[i]  <= '0;
            end
        end else if (abort) begin
            for (int i = 0; i < BF_LAT; i++) begin
                sr_en[i] <= 1'b0;
                sr_a[i]  <= '0;
                sr_b[i]  <= '0;
            end
        end else begin
            sr_en[0] <= rd_en;
            sr_a[0]  <= rd_addr_a;
            sr_b[0]  <= rd_addr_b;
            for (int i = 1; i < BF_LAT; i++) begin
                sr_en[i] <= sr_en[i-1];
                sr_a[i]  <= sr_a[i-1];
                sr_b[i]  <= sr_b[i-1];
            end
        end
    end

    assign wr_en     = sr_en[BF_LAT-1];
    assign wr_addr_a = sr_a[BF_LAT-1];
    assign wr_addr_b = sr_b[BF_LAT-1];

endmodule

// File: tb/tb_fft_sched.sv
// Self-checking bench for fft_sched: a reference address model fills read and
// write scoreboards when a run is started; a per-cycle monitor pops and
// compares them as the scheduler produces reads and writes.
module tb_fft_sched;
    import fft_pkg::*;

    localparam int L        = 2;
    localparam int NB       = 32;
    localparam int NS       = 6;
    localparam int SPAN     = NB + L;
    localparam int LAST_WR  = NS * SPAN;
    localparam int DONE_CYC = LAST_WR + 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       busy;
    logic       done;
    logic [2:0] stage;
    logic       rd_en;
    logic [5:0] rd_addr_a;
    logic [5:0] rd_addr_b;
    logic [4:0] tw_idx;
    logic       wr_en;
    logic [5:0] wr_addr_a;
    logic [5:0] wr_addr_b;

    always #5 clk = ~clk;

    fft_sched #(
        .LOG2N  (6),
        .BF_LAT (L)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .stage     (stage),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_idx    (tw_idx),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    typedef struct {
        int cyc;
        int s;
        int a;
        int b;
        int tw;
    } op_t;

    op_t rq[$];
    op_t wq[$];
    int  n_err     = 0;
    int  n_chk     = 0;
    int  cyc       = 0;
    int  t0        = 0;
    bit  run_on    = 1'b0;
    bit  done_seen = 1'b0;
    int  wr_total  = 0;
    int  pend [64];
    int  wcnt [NS][64];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (run cycle %0d)", tag, got, exp, cyc - t0);
        end
    endtask

    // Reference schedule for a run whose start is sampled at edge 'base'
    task automatic push_run(input int base);
        op_t o;
        int  half;
        int  pos;
        int  grp;
        t0 = base;
        rq.delete();
        wq.delete();
        wr_total = 0;
        for (int i = 0; i < 64; i++) begin
            pend[i] = 0;
            for (int s = 0; s < NS; s++) wcnt[s][i] = 0;
        end
        for (int s = 0; s < NS; s++) begin
            half = 2 ** s;
            for (int k = 0; k < NB; k++) begin
                pos   = k % half;
                grp   = k / half;
                o.cyc = 1 + s * SPAN + k;
                o.s   = s;
                o.a   = grp * 2 * half + pos;
                o.b   = o.a + half;
                o.tw  = pos * (NB / half);
                rq.push_back(o);
                o.cyc = o.cyc + L;
                wq.push_back(o);
            end
        end
        run_on = 1'b1;
    endtask

    task automatic monitor();
        int  rel;
        int  bad;
        bit  er;
        bit  ew;
        op_t o;
        if (!run_on) return;
        rel = cyc - t0;

        ew = (wq.size() > 0) && (wq[0].cyc == rel);
        check("wr_en", 64'(wr_en), 64'(ew));
        if (ew && wr_en) begin
            o = wq.pop_front();
            check("wr_addr_a", 64'(wr_addr_a), 64'(o.a));
            check("wr_addr_b", 64'(wr_addr_b), 64'(o.b));
            if (pend[o.a] > 0) pend[o.a]--;
            if (pend[o.b] > 0) pend[o.b]--;
            wcnt[o.s][o.a]++;
            wcnt[o.s][o.b]++;
            wr_total++;
        end

        er = (rq.size() > 0) && (rq[0].cyc == rel);
        check("rd_en", 64'(rd_en), 64'(er));
        if (er && rd_en) begin
            o = rq.pop_front();
            check("rd_addr_a", 64'(rd_addr_a), 64'(o.a));
            check("rd_addr_b", 64'(rd_addr_b), 64'(o.b));
            check("tw_idx", 64'(tw_idx), 64'(o.tw));
            check("stage", 64'(stage), 64'(o.s));
            check("hazard", 64'((pend[o.a] != 0) || (pend[o.b] != 0)), 64'(0));
            pend[o.a]++;
            pend[o.b]++;
        end

        check("busy", 64'(busy), 64'((rel >= 1) && (rel <= LAST_WR)));
        check("done", 64'(done), 64'(rel == DONE_CYC));

        if (rel == DONE_CYC) begin
            bad = 0;
            for (int s = 0; s < NS; s++)
                for (int i = 0; i < 64; i++)
                    if (wcnt[s][i] != 1) bad++;
            check("wr_total", 64'(wr_total), 64'(NS * NB));
            check("wr_once", 64'(bad), 64'(0));
            done_seen = 1'b1;
            if (start) push_run(t0 + DONE_CYC + 1);
            else       run_on = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic wait_done(input int budget);
        done_seen = 1'b0;
        for (int i = 0; i < budget && !done_seen; i++) tick();
        if (!done_seen) check("done_timeout", 64'(0), 64'(1));
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_idx,
                    wr_en, wr_addr_a, wr_addr_b});
    endfunction

    initial begin
        int dc;

        // Power-on reset
        repeat (2) tick();
        check("reset_outs", all_outs(), 64'(0));
        rst_n = 1'b1;
        tick();
        check("reset_state", 64'(dut.state_q), 64'(S_IDLE));

        // Full run; a stray start pulse mid-run must be ignored
        start = 1'b1;
        push_run(cyc + 1);
        tick();
        start = 1'b0;
        repeat (100) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(300);

        // Asynchronous reset in the middle of a run
        start = 1'b1;
        push_run(cyc + 1);
        tick();
        start = 1'b0;
        repeat (40) tick();
        run_on = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("midrun_reset_outs", all_outs(), 64'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_busy", 64'(busy), 64'(0));
        check("post_reset_state", 64'(dut.state_q), 64'(S_IDLE));

        // Abort at cycle 50
        start = 1'b1;
        push_run(cyc + 1);
        tick();
        start = 1'b0;
        repeat (50) tick();
        run_on = 1'b0;
        abort  = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_rd_en", 64'(rd_en), 64'(0));
        check("abort_wr_en", 64'(wr_en), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        dc = 0;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (done) dc++;
        end
        check("abort_no_done", 64'(dc), 64'(0));
        check("abort_state", 64'(dut.state_q), 64'(S_IDLE));

        // Full run after abort
        start = 1'b1;
        push_run(cyc + 1);
        tick();
        start = 1'b0;
        wait_done(300);

        // Start held high: two back-to-back runs
        start = 1'b1;
        push_run(cyc + 1);
        wait_done(300);
        wait_done(300);
        start  = 1'b0;
        run_on = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_after_hold", 64'({rd_en, busy}), 64'(0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
